// File: rtl/uart_tx_seq.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_seq
// Description : UART transmitter sequencer. Accepts a DATA_W-bit payload on
//               start (while idle) and serialises it as start bit, data bits
//               LSB first, optional parity bit and one stop bit, each held for
//               CLKS_PER_BIT clock cycles. Outputs tx/busy/done are registered.
//               Build option: define UART_TX_PARITY_EN to insert a parity bit
//               (even, or odd when PARITY_ODD=1) between data and stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_seq #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              load_en,
    output logic              busy,
    output logic              tx,
    output logic              done
);

    localparam int                 C_BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [15:0]        C_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [C_BIT_W-1:0] C_BIT_LAST  = C_BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         baud_q, baud_d;
    logic [C_BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                w_bit_end;
    logic [C_BIT_W-1:0]  w_next_bit;

    assign w_bit_end  = (baud_q == C_BAUD_LAST);
    assign w_next_bit = C_BIT_W'(bit_q + 1'b1);

`ifdef UART_TX_PARITY_EN
    logic w_parity;
    // Parity covers the captured payload; odd parity is the complement of even.
    assign w_parity = (^shift_q) ^ PARITY_ODD[0];
`else
    // Parity is not built; the polarity parameter is deliberately inert here.
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = PARITY_ODD[0];
`endif

    // Capture strobe for an external holding register; reset masks it.
    assign load_en = start & (state_q == S_IDLE) & ~rst;

    assign busy = busy_q;
    assign tx   = tx_q;
    assign done = done_q;

    // State register and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; tx/busy/done are computed one edge early so the
    // registered line changes exactly on each bit boundary.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    state_d = S_START;
                    shift_d = data_in;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    if (bit_q == C_BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = w_parity;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = w_next_bit;
                        tx_d  = shift_q[w_next_bit];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (w_bit_end) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_seq.md
UART_TX_SEQ -- requirements
Module: uart_tx_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the number of payload bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per bit period (legal range 2..65535).
REQ-003 The block SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: transmit request, sampled every clk edge.
REQ-007 Port data_in, input, DATA_W bits: payload, valid while start is high.
REQ-008 Port load_en, output, 1 bit: capture strobe for an external holding register, combinational = start AND (state==IDLE) AND NOT rst.
REQ-009 Port busy, output, 1 bit: registered, high whenever state != IDLE.
REQ-010 Port tx, output, 1 bit: registered serial line, idle high.
REQ-011 Port done, output, 1 bit: registered, one-cycle pulse on frame completion.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-013 In IDLE with start=1 at edge k, the block SHALL capture data_in into an internal shift register, enter START, and drive tx=0 and busy=1 from edge k onward.
REQ-014 start SHALL be ignored in every state other than IDLE; load_en SHALL stay 0 there.
REQ-015 A baud counter SHALL count 0..CLKS_PER_BIT-1, clear on every state entry, and end each bit period when it reaches CLKS_PER_BIT-1.
REQ-016 Each bit (start, each data bit, parity, stop) SHALL hold tx for exactly CLKS_PER_BIT cycles.
REQ-017 DATA SHALL send bits LSB first; a bit counter 0..DATA_W-1 SHALL advance at each bit-period end and leave DATA after bit DATA_W-1.
REQ-018 STOP SHALL drive tx=1; at its bit-period end the FSM SHALL return to IDLE, clear busy and pulse done for exactly one cycle.
REQ-019 Frame length from the accept edge to done SHALL be (DATA_W+2)*CLKS_PER_BIT cycles without parity, and (DATA_W+3)*CLKS_PER_BIT cycles with parity.
REQ-020 start=1 in the cycle done is high SHALL be accepted (state is IDLE), giving back-to-back frames with no idle bit.
REQ-021 The internal shift register SHALL NOT change after capture until the next accepted start.

Reset
REQ-022 When rst=1 at a clk edge, the block SHALL set state=IDLE, tx=1, busy=0, done=0, and clear the baud counter, bit counter and shift register.
REQ-023 rst SHALL dominate start in the same cycle: no capture, and load_en=0.
REQ-024 rst mid-frame SHALL abort the frame: tx=1 from that edge, no done pulse.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, the block SHALL insert state PARITY between DATA and STOP, transmitting XOR of the payload (even) or its complement (PARITY_ODD=1).
REQ-026 Without UART_TX_PARITY_EN, DATA SHALL go directly to STOP, and PARITY_ODD SHALL have no effect.

Verification (bench uses CLKS_PER_BIT=4, DATA_W=8)
REQ-027 Reset, then idle 10 cycles -> tx=1, busy=0, done=0, load_en=0 throughout.
REQ-028 start=1 for one cycle, data_in=8'hA5 -> tx pattern 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; done pulses 40 cycles after accept (44 with parity, parity bit=0 even).
REQ-029 start held high continuously with data 8'h00, then 8'hFF -> load_en high only on the accept cycles, two frames back-to-back, busy stays low for at most 1 cycle between them.
REQ-030 start pulsed mid-frame (cycle 12 of a 8'h3C frame) -> ignored, frame bits unchanged, single done pulse.
REQ-031 rst asserted at cycle 20 of a frame -> tx=1, busy=0 from that edge, no done; the next start transmits normally.
REQ-032 UART_TX_PARITY_EN defined, PARITY_ODD=1, data 8'h01 -> parity bit=0; data 8'h03 -> parity bit=1.
